// File: rtl/llc_mem_lookup_issue.sv
// llc_mem_lookup_issue: issues LLC tag/state SRAM reads for lookup requests and
// presents forwarded lookup packets from a 2-entry buffer over valid/ready.
module llc_mem_lookup_issue #(
    parameter int WAYS       = 16,
    parameter int WAY_BITS   = 4,
    parameter int TAG_BITS   = 20,
    parameter int STATE_BITS = 3,
    parameter int SET_BITS   = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid_in,
    output logic                         req_ready_out,
    input  logic [SET_BITS-1:0]          req_set,
    input  logic [TAG_BITS-1:0]          req_tag,
    output logic                         mem_rd_en,
    output logic [SET_BITS-1:0]          mem_rd_set,
    input  logic [WAYS*TAG_BITS-1:0]     mem_rd_tags,
    input  logic [WAYS*STATE_BITS-1:0]   mem_rd_states,
    input  logic [WAY_BITS-1:0]          mem_rd_evict_way,
    input  logic                         wr_en,
    input  logic [SET_BITS-1:0]          wr_set,
    input  logic [WAY_BITS-1:0]          wr_way,
    input  logic [TAG_BITS-1:0]          wr_tag,
    input  logic [STATE_BITS-1:0]        wr_state,
    input  logic                         wr_evict_en,
    input  logic [WAY_BITS-1:0]          wr_evict_way,
    output logic                         pkt_valid_out,
    input  logic                         pkt_ready_in,
    output logic [SET_BITS-1:0]          pkt_set,
    output logic [TAG_BITS-1:0]          pkt_tag,
    output logic [WAYS*TAG_BITS-1:0]     pkt_tags,
    output logic [WAYS*STATE_BITS-1:0]   pkt_states,
    output logic [WAY_BITS-1:0]          pkt_evict_way
);
    logic                       inflight_q;
    logic [SET_BITS-1:0]        if_set_q;
    logic [TAG_BITS-1:0]        if_tag_q;
    logic                       wp_q, ep_q;
    logic [WAY_BITS-1:0]        wp_way_q, ep_way_q;
    logic [TAG_BITS-1:0]        wp_tag_q;
    logic [STATE_BITS-1:0]      wp_state_q;
    logic [1:0]                 cnt_q, cnt_d;
    logic                       wptr_q, rptr_q;
    logic [SET_BITS-1:0]        b_set_q    [2];
    logic [TAG_BITS-1:0]        b_tag_q    [2];
    logic [WAYS*TAG_BITS-1:0]   b_tags_q   [2];
    logic [WAYS*STATE_BITS-1:0] b_states_q [2];
    logic [WAY_BITS-1:0]        b_ev_q     [2];
    logic                       pop, accept, cap_hit;
    logic [WAYS*TAG_BITS-1:0]   cap_tags;
    logic [WAYS*STATE_BITS-1:0] cap_states;
    logic [WAY_BITS-1:0]        cap_ev;

    assign pkt_valid_out = cnt_q != 2'd0;
    assign pop           = pkt_valid_out & pkt_ready_in;
    assign req_ready_out = (cnt_q + {1'b0, inflight_q} < 2'd2) | pop;
    assign accept        = req_valid_in & req_ready_out & rst;
    assign mem_rd_en     = accept;
    assign mem_rd_set    = req_set;
    assign cnt_d         = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    assign cap_hit       = wr_set == if_set_q;
    assign pkt_set       = b_set_q[rptr_q];
    assign pkt_tag       = b_tag_q[rptr_q];
    assign pkt_tags      = b_tags_q[rptr_q];
    assign pkt_states    = b_states_q[rptr_q];
    assign pkt_evict_way = b_ev_q[rptr_q];

    // SRAM data misses writes made in the issue cycle; replay them, then let capture-cycle writes win
    always_comb begin
        cap_tags   = mem_rd_tags;
        cap_states = mem_rd_states;
        cap_ev     = (wr_evict_en && cap_hit) ? wr_evict_way : ep_q ? ep_way_q : mem_rd_evict_way;
        if (wp_q) begin
            cap_tags[wp_way_q*TAG_BITS +: TAG_BITS]       = wp_tag_q;
            cap_states[wp_way_q*STATE_BITS +: STATE_BITS] = wp_state_q;
        end
        if (wr_en && cap_hit) begin
            cap_tags[wr_way*TAG_BITS +: TAG_BITS]       = wr_tag;
            cap_states[wr_way*STATE_BITS +: STATE_BITS] = wr_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= 1'b0;
            if_set_q   <= '0;
            if_tag_q   <= '0;
            wp_q       <= 1'b0;
            wp_way_q   <= '0;
            wp_tag_q   <= '0;
            wp_state_q <= '0;
            ep_q       <= 1'b0;
            ep_way_q   <= '0;
            cnt_q      <= '0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                b_set_q[i]    <= '0;
                b_tag_q[i]    <= '0;
                b_tags_q[i]   <= '0;
                b_states_q[i] <= '0;
                b_ev_q[i]     <= '0;
            end
        end else begin
            inflight_q <= accept;
            cnt_q      <= cnt_d;
            if (accept) begin
                if_set_q   <= req_set;
                if_tag_q   <= req_tag;
                wp_q       <= wr_en && wr_set == req_set;
                wp_way_q   <= wr_way;
                wp_tag_q   <= wr_tag;
                wp_state_q <= wr_state;
                ep_q       <= wr_evict_en && wr_set == req_set;
                ep_way_q   <= wr_evict_way;
            end
            if (pop)
                rptr_q <= ~rptr_q;
            // an entry leaving this cycle is already consumed, so it skips the update
            for (int i = 0; i < 2; i++) begin
                if (!(pop && 1'(i) == rptr_q) && b_set_q[i] == wr_set) begin
                    if (wr_en) begin
                        b_tags_q[i][wr_way*TAG_BITS +: TAG_BITS]       <= wr_tag;
                        b_states_q[i][wr_way*STATE_BITS +: STATE_BITS] <= wr_state;
                    end
                    if (wr_evict_en)
                        b_ev_q[i] <= wr_evict_way;
                end
            end
            if (inflight_q) begin
                wptr_q             <= ~wptr_q;
                b_set_q[wptr_q]    <= if_set_q;
                b_tag_q[wptr_q]    <= if_tag_q;
                b_tags_q[wptr_q]   <= cap_tags;
                b_states_q[wptr_q] <= cap_states;
                b_ev_q[wptr_q]     <= cap_ev;
            end
        end
    end
endmodule

// File: tb/tb_llc_mem_lookup_issue.sv
// tb_llc_mem_lookup_issue: SRAM model plus scoreboard; a popped packet must equal
// the SRAM contents of its set as of the end of the previous cycle.
module tb_llc_mem_lookup_issue;
    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid_in, req_ready_out;
    logic [9:0]   req_set;
    logic [19:0]  req_tag;
    logic         mem_rd_en;
    logic [9:0]   mem_rd_set;
    logic [319:0] mem_rd_tags = '0;
    logic [47:0]  mem_rd_states = '0;
    logic [3:0]   mem_rd_evict_way = '0;
    logic         wr_en;
    logic [9:0]   wr_set;
    logic [3:0]   wr_way;
    logic [19:0]  wr_tag;
    logic [2:0]   wr_state;
    logic         wr_evict_en;
    logic [3:0]   wr_evict_way;
    logic         pkt_valid_out, pkt_ready_in;
    logic [9:0]   pkt_set;
    logic [19:0]  pkt_tag;
    logic [319:0] pkt_tags;
    logic [47:0]  pkt_states;
    logic [3:0]   pkt_evict_way;

    llc_mem_lookup_issue dut (
        .clk(clk), .rst(rst),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_set(req_set), .req_tag(req_tag),
        .mem_rd_en(mem_rd_en), .mem_rd_set(mem_rd_set),
        .mem_rd_tags(mem_rd_tags), .mem_rd_states(mem_rd_states), .mem_rd_evict_way(mem_rd_evict_way),
        .wr_en(wr_en), .wr_set(wr_set), .wr_way(wr_way), .wr_tag(wr_tag), .wr_state(wr_state),
        .wr_evict_en(wr_evict_en), .wr_evict_way(wr_evict_way),
        .pkt_valid_out(pkt_valid_out), .pkt_ready_in(pkt_ready_in),
        .pkt_set(pkt_set), .pkt_tag(pkt_tag), .pkt_tags(pkt_tags),
        .pkt_states(pkt_states), .pkt_evict_way(pkt_evict_way)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  s;
        logic [19:0] t;
        int          c;
    } ent_t;

    ent_t         q[$];
    ent_t         e;
    int           n_cmp = 0, n_err = 0, cyc = 0, n5;
    bit [19:0]    m_tag [1024][16];
    bit [2:0]     m_st  [1024][16];
    bit [3:0]     m_ev  [1024];
    logic         ev, pp, ra, acc;
    logic [319:0] et;
    logic [47:0]  es;

    task automatic chk(input string tag, input logic [319:0] act, input logic [319:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // SRAM: 1-cycle read returning pre-write data on a same-cycle write
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_en) begin
            for (int w = 0; w < 16; w++) begin
                mem_rd_tags[w*20 +: 20] <= m_tag[mem_rd_set][w];
                mem_rd_states[w*3 +: 3] <= m_st[mem_rd_set][w];
            end
            mem_rd_evict_way <= m_ev[mem_rd_set];
        end
        if (wr_en) begin
            m_tag[wr_set][wr_way] <= wr_tag;
            m_st[wr_set][wr_way]  <= wr_state;
        end
        if (wr_evict_en)
            m_ev[wr_set] <= wr_evict_way;
    end

    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            chk("rst_valid", pkt_valid_out, 0);
            chk("rst_ready", req_ready_out, 1);
            chk("rst_rd_en", mem_rd_en, 0);
            chk("rst_set", pkt_set, 0);
            chk("rst_tag", pkt_tag, 0);
            chk("rst_tags", pkt_tags, 0);
            chk("rst_states", pkt_states, 0);
            chk("rst_evict", pkt_evict_way, 0);
        end else begin
            ev  = q.size() > 0 && cyc >= q[0].c + 2;
            pp  = ev & pkt_ready_in;
            ra  = q.size() < 2 || pp;
            acc = req_valid_in & ra;
            chk("pkt_valid", pkt_valid_out, ev);
            chk("req_ready", req_ready_out, ra);
            chk("rd_en", mem_rd_en, acc);
            if (acc)
                chk("rd_set", mem_rd_set, req_set);
            if (pp) begin
                e = q.pop_front();
                for (int w = 0; w < 16; w++) begin
                    et[w*20 +: 20] = m_tag[e.s][w];
                    es[w*3 +: 3]   = m_st[e.s][w];
                end
                chk("pkt_set", pkt_set, e.s);
                chk("pkt_tag", pkt_tag, e.t);
                chk("pkt_tags", pkt_tags, et);
                chk("pkt_states", pkt_states, es);
                chk("pkt_evict", pkt_evict_way, m_ev[e.s]);
            end
            if (acc)
                q.push_back('{req_set, req_tag, cyc});
        end
    end

    initial begin
        rst = 1'b0; req_valid_in = 1'b1; req_set = '0; req_tag = '0; pkt_ready_in = 1'b0;
        wr_en = 1'b0; wr_set = '0; wr_way = '0; wr_tag = '0; wr_state = '0;
        wr_evict_en = 1'b0; wr_evict_way = '0;
        step; step;
        req_valid_in = 1'b0; rst = 1'b1;
        step;
        // T1: single request with preloaded set 5
        wr_en = 1'b1; wr_set = 10'd5; wr_way = 4'd3; wr_tag = 20'hABCDE; wr_state = 3'd2;
        wr_evict_en = 1'b1; wr_evict_way = 4'd7;
        step;
        wr_en = 1'b0; wr_evict_en = 1'b0;
        req_valid_in = 1'b1; req_set = 10'd5; req_tag = 20'hABCDE;
        step;
        req_valid_in = 1'b0;
        @(negedge clk) chk("t1_lat1", pkt_valid_out, 0);
        step;
        pkt_ready_in = 1'b1;
        @(negedge clk);
        chk("t1_valid", pkt_valid_out, 1);
        chk("t1_set", pkt_set, 10'd5);
        chk("t1_way3_tag", pkt_tags[79:60], 20'hABCDE);
        chk("t1_way3_st", pkt_states[11:9], 3'd2);
        chk("t1_evict", pkt_evict_way, 4'd7);
        step;
        // T2: stall, fill, then pop+accept together
        pkt_ready_in = 1'b0; req_valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_set = 10'(40 + i); req_tag = 20'(i + 1);
            step;
        end
        @(negedge clk) chk("t2_full", req_ready_out, 0);
        step;
        pkt_ready_in = 1'b1;
        @(negedge clk) chk("t2_pop_acc", req_ready_out, 1);
        step;
        req_set = 10'd43; req_tag = 20'h4;
        step;
        req_valid_in = 1'b0;
        repeat (5) step;
        // T3: forwarding into buffered entries while stalled
        pkt_ready_in = 1'b0;
        wr_en = 1'b1; wr_set = 10'd9; wr_way = 4'd2; wr_tag = 20'h55; wr_state = 3'd3;
        step;
        wr_set = 10'd8; wr_tag = 20'h77;
        step;
        wr_en = 1'b0;
        req_valid_in = 1'b1; req_set = 10'd9; req_tag = 20'h9;
        step;
        req_set = 10'd8; req_tag = 20'h8;
        step;
        req_valid_in = 1'b0;
        step; step;
        wr_en = 1'b1; wr_set = 10'd9; wr_way = 4'd2; wr_tag = 20'h11; wr_state = 3'd0;
        step;
        wr_en = 1'b0; pkt_ready_in = 1'b1;
        @(negedge clk);
        chk("t3_set9", pkt_set, 10'd9);
        chk("t3_way2_tag", pkt_tags[59:40], 20'h11);
        chk("t3_way2_st", pkt_states[8:6], 3'd0);
        step;
        @(negedge clk);
        chk("t3_set8", pkt_set, 10'd8);
        chk("t3_set8_tag", pkt_tags[59:40], 20'h77);
        chk("t3_set8_st", pkt_states[8:6], 3'd3);
        step; step;
        // T4: issue-cycle write plus capture-cycle evict write
        wr_en = 1'b1; wr_set = 10'd12; wr_way = 4'd1; wr_tag = 20'h123; wr_state = 3'd3;
        wr_evict_en = 1'b1; wr_evict_way = 4'd9;
        step;
        wr_evict_en = 1'b0; pkt_ready_in = 1'b0;
        wr_tag = 20'h321; wr_state = 3'd1;
        req_valid_in = 1'b1; req_set = 10'd12; req_tag = 20'hC;
        step;
        req_valid_in = 1'b0; wr_en = 1'b0;
        wr_evict_en = 1'b1; wr_evict_way = 4'd4;
        step;
        wr_evict_en = 1'b0;
        @(negedge clk);
        chk("t4_way1_tag", pkt_tags[39:20], 20'h321);
        chk("t4_way1_st", pkt_states[5:3], 3'd1);
        chk("t4_evict", pkt_evict_way, 4'd4);
        step;
        pkt_ready_in = 1'b1;
        step; step;
        // T5: back-to-back throughput
        n5 = 0;
        req_valid_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            req_set = 10'(100 + i); req_tag = 20'(i);
            @(negedge clk);
            if (i >= 2 && mem_rd_en && pkt_valid_out)
                n5++;
            step;
        end
        chk("t5_rate", n5, 18);
        req_valid_in = 1'b0;
        repeat (3) step;
        // T6: reset with one buffered and one in-flight entry
        pkt_ready_in = 1'b0; req_valid_in = 1'b1; req_set = 10'd20; req_tag = 20'h20;
        step;
        req_set = 10'd21; req_tag = 20'h21;
        step;
        req_valid_in = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("t6_valid", pkt_valid_out, 0);
        chk("t6_ready", req_ready_out, 1);
        step;
        rst = 1'b1;
        repeat (4) step;
        @(negedge clk) chk("t6_no_stale", pkt_valid_out, 0);
        // randomised traffic on a few sets with concurrent writes
        for (int i = 0; i < 400; i++) begin
            req_valid_in = $urandom_range(0, 3) != 0;
            req_set      = 10'($urandom_range(0, 3));
            req_tag      = 20'($urandom);
            pkt_ready_in = 1'($urandom_range(0, 1));
            wr_en        = 1'($urandom_range(0, 1));
            wr_set       = 10'($urandom_range(0, 3));
            wr_way       = 4'($urandom);
            wr_tag       = 20'($urandom);
            wr_state     = 3'($urandom);
            wr_evict_en  = $urandom_range(0, 3) == 0;
            wr_evict_way = 4'($urandom);
            step;
        end
        req_valid_in = 1'b0; wr_en = 1'b0; wr_evict_en = 1'b0; pkt_ready_in = 1'b1;
        repeat (5) step;
        chk("drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
